// File: rtl/add_seq_pkg.sv
// Shared types and sizing helpers for the chunked wide-adder sequencer.
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_seq_state_t;

    // Number of adder-slice passes needed to cover the full operand width.
    function automatic int calc_nchunk(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    // Number of meaningful bits in the final (possibly partial) slice.
    function automatic int calc_last_w(input int width, input int chunk);
        return width - (calc_nchunk(width, chunk) - 1) * chunk;
    endfunction

endpackage

// File: rtl/add_seq_ctrl_add_chunk.sv
// Combinational W-bit adder slice with carry in and carry out.
module add_chunk #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    // Plain ripple add; synthesis picks the adder architecture.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-cycle wide adder: latches one operand pair, adds it one slice per
// clock through a single add_chunk instance, then holds the result until the
// consumer takes it. Optional signed-overflow output enabled by the macro
// ADD_SEQ_OVF_EN.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef ADD_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    // A slice wider than the operand collapses to a single full-width pass.
    localparam int CW       = (CHUNK < WIDTH) ? CHUNK : WIDTH;
    localparam int NCHUNK   = calc_nchunk(WIDTH, CW);
    localparam int LAST_W   = calc_last_w(WIDTH, CW);
    localparam int IDX_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    add_seq_state_t   state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
`ifdef ADD_SEQ_OVF_EN
    logic             ovf_q, ovf_d;
    logic             msb_cin;
`endif

    logic [CW-1:0]    slice_a, slice_b, slice_sum;
    logic             slice_cout;
    logic             msb_cout;

    // Select the operand slice for the current index; bits past WIDTH read as zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        slice_a = '0;
        slice_b = '0;
        for (int j = 0; j < CW; j++) begin
            if (int'(idx_q) * CW + j < WIDTH) begin
                slice_a[j] = a_q[int'(idx_q) * CW + j];
                slice_b[j] = b_q[int'(idx_q) * CW + j];
            end
        end
    end

    add_chunk #(.W(CW)) u_add_chunk (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // With a partial last slice the zero-fed upper bits make the first padded
    // sum bit equal to the carry out of bit WIDTH-1.
    if (LAST_W < CW) begin : g_partial_last
        assign msb_cout = slice_sum[LAST_W];
    end else begin : g_full_last
        assign msb_cout = slice_cout;
    end

`ifdef ADD_SEQ_OVF_EN
    // Carry into the MSB recovered from the MSB sum bit and its operand bits.
    assign msb_cin = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_sum[LAST_W-1];
`endif

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef ADD_SEQ_OVF_EN
        ovf_d       = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    carry_d    = cin;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (i / CW == int'(idx_q)) begin
                        sum_d[i] = slice_sum[i % CW];
                    end
                end
                carry_d = slice_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    cout_d      = msb_cout;
`ifdef ADD_SEQ_OVF_EN
                    ovf_d       = msb_cin ^ msb_cout;
`endif
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef ADD_SEQ_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign busy      = busy_q;
`ifdef ADD_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (default 65-bit, 16-bit slices).
// Honours ADD_SEQ_OVF_EN when the design is built with it.
module tb_add_seq_ctrl;

    localparam int WIDTH  = 65;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef ADD_SEQ_OVF_EN
    logic             ovf;
`endif

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [WIDTH-1:0] last_sum;
    logic             last_cout;

    add_seq_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef ADD_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand65();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[WIDTH-1:0];
    endfunction

`ifdef ADD_SEQ_OVF_EN
    // Signed overflow: the true two's-complement sum does not fit in WIDTH bits.
    function automatic logic model_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                       input logic c);
        logic signed [WIDTH+1:0] s;
        s = $signed({{2{x[WIDTH-1]}}, x}) + $signed({{2{y[WIDTH-1]}}, y})
            + $signed({{(WIDTH+1){1'b0}}, c});
        return !((s[WIDTH+1:WIDTH-1] == 3'b000) || (s[WIDTH+1:WIDTH-1] == 3'b111));
    endfunction
`endif

    // Present an operand pair, let it be accepted, then scramble the inputs.
    task automatic accept_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                             input logic tc);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        check("in_ready_idle", 66'(in_ready), 66'(1));
        @(negedge clk);
        a = rand65(); b = rand65(); cin = 1'($urandom); in_valid = 1'b1;
        check("busy_run", 66'(busy), 66'(1));
    endtask

    // Wait (bounded) for the result and compare it with plain arithmetic.
    task automatic wait_result(input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                               input logic ec);
        int          lat;
        logic [65:0] full;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        full = {1'b0, ea} + {1'b0, eb} + {65'd0, ec};
        check("latency", 66'(lat), 66'(NCHUNK));
        check("sum", 66'(sum), 66'(full[WIDTH-1:0]));
        check("cout", 66'(cout), 66'(full[WIDTH]));
        check("in_ready_done", 66'(in_ready), 66'(0));
`ifdef ADD_SEQ_OVF_EN
        check("ovf", 66'(ovf), 66'(model_ovf(ea, eb, ec)));
`endif
        last_sum  = full[WIDTH-1:0];
        last_cout = full[WIDTH];
    endtask

    // Complete the output handshake and confirm the return to IDLE.
    task automatic release_out();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", 66'(out_valid), 66'(0));
        check("in_ready_back", 66'(in_ready), 66'(1));
        check("busy_idle", 66'(busy), 66'(0));
    endtask

    initial begin
        logic [WIDTH-1:0] x, y;
        logic             c;
        int               acc[$];
        int               guard;

        // Reset held for two edges with a live request.
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        a = rand65(); b = rand65(); cin = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 66'(in_ready), 66'(1));
        check("rst_out_valid", 66'(out_valid), 66'(0));
        check("rst_busy", 66'(busy), 66'(0));
        check("rst_sum", 66'(sum), 66'(0));
        check("rst_cout", 66'(cout), 66'(0));
`ifdef ADD_SEQ_OVF_EN
        check("rst_ovf", 66'(ovf), 66'(0));
`endif
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Full-width ripple.
        x = {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        accept_op(x, '0, 1'b1);
        wait_result(x, '0, 1'b1);
        check("ripple_sum_zero", 66'(sum), 66'(0));
        release_out();

        // Carry across the first slice boundary.
        x = 65'h0_0000_0000_0000_FFFF;
        y = 65'd1;
        accept_op(x, y, 1'b0);
        wait_result(x, y, 1'b0);
        check("boundary_sum", 66'(sum), 66'(65'h0_0000_0000_0001_0000));
        release_out();

        // Most positive value plus one: signed overflow, no unsigned carry.
        x = 65'h0_FFFF_FFFF_FFFF_FFFF;
        accept_op(x, 65'd1, 1'b0);
        wait_result(x, 65'd1, 1'b0);
        release_out();

        // Backpressure: result held, new requests ignored.
        x = rand65(); y = rand65(); c = 1'($urandom);
        accept_op(x, y, c);
        wait_result(x, y, c);
        for (int k = 0; k < 10; k++) begin
            a = rand65(); b = rand65(); cin = 1'($urandom); in_valid = 1'b1;
            @(negedge clk);
            check("bp_sum_hold", 66'(sum), 66'(last_sum));
            check("bp_cout_hold", 66'(cout), 66'(last_cout));
            check("bp_in_ready", 66'(in_ready), 66'(0));
            check("bp_out_valid", 66'(out_valid), 66'(1));
        end
        x = rand65(); y = rand65(); c = 1'($urandom);
        a = x; b = y; cin = c; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", 66'(out_valid), 66'(0));
        check("bp_release_ready", 66'(in_ready), 66'(1));
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_accept", 66'(busy), 66'(1));
        check("bp_next_ready", 66'(in_ready), 66'(0));
        wait_result(x, y, c);
        release_out();

        // Reset asserted for the second RUN edge discards the operation.
        accept_op(rand65(), rand65(), 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 66'(in_ready), 66'(1));
        check("midrst_out_valid", 66'(out_valid), 66'(0));
        check("midrst_busy", 66'(busy), 66'(0));
        check("midrst_sum", 66'(sum), 66'(0));
        check("midrst_cout", 66'(cout), 66'(0));
        in_valid = 1'b0;
        rst_n    = 1'b1;
        accept_op(65'd3, 65'd4, 1'b1);
        wait_result(65'd3, 65'd4, 1'b1);
        check("small_sum", 66'(sum), 66'(8));
        release_out();

        // Randomized operations with random consumer delay.
        for (int n = 0; n < 24; n++) begin
            x = rand65(); y = rand65(); c = 1'($urandom);
            if (n % 6 == 0) y = ~x;
            accept_op(x, y, c);
            wait_result(x, y, c);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check("rand_hold", 66'(sum), 66'(last_sum));
            end
            release_out();
        end

        // Back-to-back throughput with constant handshakes.
        @(negedge clk);
        a = rand65(); b = rand65(); cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (in_ready) acc.push_back(cyc);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("tput_count", 66'(acc.size()), 66'(9));
        for (int i = 1; i < acc.size(); i++) begin
            check("tput_gap", 66'(acc[i] - acc[i-1]), 66'(NCHUNK + 2));
        end
        guard = 0;
        while ((busy || !in_ready) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        check("drain_idle", 66'(busy), 66'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
